// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM state type and default operand width for serial_sub_ctrl
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// rtl/serial_sub_ctrl_fs_cell.sv - 1-bit full-subtractor cell (d = x - y - bi)
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference is the three-way parity; a borrow is needed when y+bi exceeds x
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial a - b - bin controller; SERIAL_SUB_CTRL_SAT_EN selects saturating diff
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic             r_bout;

  logic w_x;
  logic w_y;
  logic w_d;
  logic w_bo;

  // The single shared cell always looks at the bit selected by the counter
  assign w_x = r_a[r_cnt];
  assign w_y = r_b[r_cnt];

  fs_cell u_cell (
    .x  (w_x),
    .y  (w_y),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  // Control FSM with registered busy/done and the serial result datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_diff[r_cnt] <= w_d;
          r_borrow      <= w_bo;
          if (r_cnt == LAST_BIT) begin
            // Counter parks on the last bit instead of wrapping
            r_bout  <= w_bo;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
`ifdef SERIAL_SUB_CTRL_SAT_EN
            if (w_bo) begin
              r_diff <= '0;
            end
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - self-checking bench for serial_sub_ctrl at WIDTH=8
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs [8];

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_diff(input logic [7:0] wrapped, input logic bo);
`ifdef SERIAL_SUB_CTRL_SAT_EN
    if (bo) return 8'h00;
`endif
    return wrapped;
  endfunction

  // One operation: cycle 1 is the sample just after the accepting edge.
  // inj > 0 raises start with a=0x10 during busy cycle inj for one edge.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ibin, input logic [7:0] ed, input logic ebo,
                        input bit sync_neg, input int inj);
    int cyc;
    int busy_cnt;
    int extra_done;
    int overlap;
    logic [7:0] held_d;
    logic       held_b;
    if (sync_neg) @(negedge clk);
    start = 1'b1; a = ia; b = ib; bin = ibin;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; busy_cnt = 0; extra_done = 0; overlap = 0;
    while (cyc <= 20 && !done) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (cyc == inj) begin
        start = 1'b1; a = 8'h10; b = 8'h00;
      end else if (cyc == inj + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (busy && done) overlap++;
    chk({tag, "_latency"}, cyc, 9);
    chk({tag, "_busy_cycles"}, busy_cnt, 8);
    chk({tag, "_diff"}, diff, exp_diff(ed, ebo));
    chk({tag, "_bout"}, bout, ebo);
    held_d = diff;
    held_b = bout;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) extra_done++;
      if (busy && done) overlap++;
    end
    chk({tag, "_single_done"}, extra_done, 0);
    chk({tag, "_hold"}, {diff, bout}, {held_d, held_b});
    chk({tag, "_overlap"}, overlap, 0);
  endtask

  initial begin
    int done_idx [$];
    int overlap;
    int rst_done;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    vecs[5] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0};
    vecs[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_bout", bout, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
             vecs[i].d, vecs[i].bo, 1'b1, 0);
    end

    // Start pulse during busy cycle 3 must be ignored
    run_op("ignore_start", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b1, 3);

    // Reset during SHIFT cycle 4 aborts with no done pulse
    @(negedge clk);
    start = 1'b1; a = 8'h33; b = 8'h11; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    rst_done = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) rst_done++;
    end
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 0);
    chk("midrst_no_done", rst_done, 0);

    // start held high for 30 cycles: back-to-back results every 10 cycles
    @(negedge clk);
    start = 1'b1; a = 8'h05; b = 8'h03; bin = 1'b0;
    overlap = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done) done_idx.push_back(k);
      if (busy && done) overlap++;
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b_pulses", done_idx.size(), 3);
    if (done_idx.size() == 3) begin
      chk("b2b_first", done_idx[0], 9);
      chk("b2b_gap1", done_idx[1] - done_idx[0], 10);
      chk("b2b_gap2", done_idx[2] - done_idx[1], 10);
    end
    chk("b2b_overlap", overlap, 0);
    chk("b2b_diff", diff, 8'h02);
    repeat (12) @(posedge clk);
    #1;
    chk("b2b_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
